// File: rtl/led_pkg.sv
// Shared state encoding, default bit timing and pixel-word helper for the
// serial LED frame streamer.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SEND  = 2'd2,
    LATCH = 2'd3
  } state_t;

  localparam int LED_T0H    = 4;
  localparam int LED_T1H    = 8;
  localparam int LED_TBIT   = 15;
  localparam int LED_TLATCH = 1000;

  // GRB ordering: green byte leaves the line first.
  function automatic logic [23:0] grb_word(input logic g, input logic r, input logic b,
                                           input logic [7:0] level);
    grb_word = {(g ? level : 8'h00), (r ? level : 8'h00), (b ? level : 8'h00)};
  endfunction

endpackage

// File: rtl/ws_bit_encoder.sv
// Turns one data bit into a TBIT-cycle high/low pulse; bit_done marks the
// penultimate cycle so the caller can line up the next bit with no gap.
module ws_bit_encoder #(
  parameter int T0H  = 4,
  parameter int T1H  = 8,
  parameter int TBIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_in,
  output logic data_out,
  output logic bit_done
);

  localparam int CW = $clog2(TBIT);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          busy_r;
  logic          bit_r;
  logic          data_r;
  logic          done_r;

  assign cnt_nxt_s = cnt_r + CW'(1);
  assign data_out  = data_r;
  assign bit_done  = done_r;

  // Bit-period counter and registered waveform; a start on the last cycle restarts seamlessly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= '0;
      busy_r <= 1'b0;
      bit_r  <= 1'b0;
      data_r <= 1'b0;
      done_r <= 1'b0;
    end else if (start) begin
      cnt_r  <= '0;
      busy_r <= 1'b1;
      bit_r  <= bit_in;
      data_r <= 1'b1;
      done_r <= 1'b0;
    end else if (busy_r) begin
      if (cnt_r == CW'(TBIT - 1)) begin
        cnt_r  <= '0;
        busy_r <= 1'b0;
        data_r <= 1'b0;
        done_r <= 1'b0;
      end else begin
        cnt_r  <= cnt_nxt_s;
        data_r <= bit_r ? (cnt_nxt_s < CW'(T1H)) : (cnt_nxt_s < CW'(T0H));
        done_r <= (cnt_nxt_s == CW'(TBIT - 2));
      end
    end else begin
      data_r <= 1'b0;
      done_r <= 1'b0;
    end
  end

endmodule

// File: rtl/frame_streamer.sv
// Streams a captured 64-pixel RGB board as GRB serial LED data, then holds
// the line low for the latch gap and pulses frame_done.
module frame_streamer
  import led_pkg::*;
#(
  parameter int         T0H        = LED_T0H,
  parameter int         T1H        = LED_T1H,
  parameter int         TBIT       = LED_TBIT,
  parameter int         TLATCH     = LED_TLATCH,
  parameter logic [7:0] BRIGHTNESS = 8'h20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_valid,
  output logic        frame_ready,
  input  logic [63:0] red_board,
  input  logic [63:0] green_board,
  input  logic [63:0] blue_board,
  output logic        data_out,
  output logic        frame_done
);

  localparam int TMAX = (TBIT > TLATCH) ? TBIT : TLATCH;
  localparam int LCW  = $clog2(TMAX);

  state_t         state_r;
  logic [63:0]    red_r;
  logic [63:0]    green_r;
  logic [63:0]    blue_r;
  logic [5:0]     pixel_r;
  logic [4:0]     bit_cnt_r;
  logic [23:0]    word_r;
  logic [LCW-1:0] cyc_r;
  logic           tail_r;
  logic           next_start_r;
  logic           ready_r;
  logic           done_r;
  logic [23:0]    grb_s;
  logic           start_s;
  logic           bit_s;
  logic           bit_done_s;

  assign grb_s       = grb_word(green_r[pixel_r], red_r[pixel_r], blue_r[pixel_r], BRIGHTNESS);
  // LOAD feeds the fresh word's MSB straight to the encoder so it starts on the LOAD edge.
  assign start_s     = (state_r == LOAD) || next_start_r;
  assign bit_s       = (state_r == LOAD) ? grb_s[23] : word_r[23];
  assign frame_ready = ready_r;
  assign frame_done  = done_r;

  ws_bit_encoder #(.T0H(T0H), .T1H(T1H), .TBIT(TBIT)) u_enc (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_s),
    .bit_in   (bit_s),
    .data_out (data_out),
    .bit_done (bit_done_s)
  );

  // Frame sequencing: capture, per-pixel load, bit stepping and latch gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      red_r        <= 64'h0;
      green_r      <= 64'h0;
      blue_r       <= 64'h0;
      pixel_r      <= 6'd0;
      bit_cnt_r    <= 5'd0;
      word_r       <= 24'h0;
      cyc_r        <= '0;
      tail_r       <= 1'b0;
      next_start_r <= 1'b0;
      ready_r      <= 1'b1;
      done_r       <= 1'b0;
    end else begin
      next_start_r <= 1'b0;
      done_r       <= 1'b0;
      case (state_r)
        IDLE: begin
          if (frame_valid) begin
            red_r     <= red_board;
            green_r   <= green_board;
            blue_r    <= blue_board;
            pixel_r   <= 6'd0;
            bit_cnt_r <= 5'd0;
            ready_r   <= 1'b0;
            state_r   <= LOAD;
          end else begin
            ready_r <= 1'b1;
          end
        end
        LOAD: begin
          word_r    <= grb_s;
          bit_cnt_r <= 5'd0;
          state_r   <= SEND;
        end
        SEND: begin
          // bit_done fires one cycle early: the final cycle is either the next start or LOAD.
          if (bit_done_s) begin
            if (bit_cnt_r != 5'd23) begin
              word_r       <= {word_r[22:0], 1'b0};
              bit_cnt_r    <= bit_cnt_r + 5'd1;
              next_start_r <= 1'b1;
            end else if (pixel_r != 6'd63) begin
              pixel_r <= pixel_r + 6'd1;
              state_r <= LOAD;
            end else begin
              tail_r  <= 1'b1;
              cyc_r   <= '0;
              state_r <= LATCH;
            end
          end else begin
            state_r <= SEND;
          end
        end
        LATCH: begin
          // The tail cycle finishes the last bit period before the gap count starts.
          if (tail_r) begin
            tail_r <= 1'b0;
          end else if (cyc_r == LCW'(TLATCH - 1)) begin
            ready_r <= 1'b1;
            state_r <= IDLE;
          end else begin
            cyc_r  <= cyc_r + LCW'(1);
            done_r <= (cyc_r == LCW'(TLATCH - 2));
          end
        end
        default: begin
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_streamer.sv
// Directed bench for frame_streamer: records data_out per cycle and compares
// against a hand-timed waveform model (15-cycle bits, 8/4 high, 1000 latch).
module tb_frame_streamer;

  localparam int NS = 24044;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_valid = 1'b0;
  logic [63:0] red_board = 64'h0;
  logic [63:0] green_board = 64'h0;
  logic [63:0] blue_board = 64'h0;
  logic        frame_ready;
  logic        data_out;
  logic        frame_done;

  int n_chk = 0;
  int n_fail = 0;

  logic        dq  [NS];
  logic        dnq [NS];
  logic        rq  [NS];
  logic [63:0] m_r, m_g, m_b;

  frame_streamer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .red_board   (red_board),
    .green_board (green_board),
    .blue_board  (blue_board),
    .data_out    (data_out),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] model_word(input int p);
    logic [7:0] g, r, b;
    g = m_g[p] ? 8'h20 : 8'h00;
    r = m_r[p] ? 8'h20 : 8'h00;
    b = m_b[p] ? 8'h20 : 8'h00;
    return {g, r, b};
  endfunction

  // Sample 0 is the LOAD cycle; bit j occupies samples 1+15j .. 15+15j.
  function automatic logic exp_dout(input int s);
    int j, c;
    logic [23:0] w;
    logic bv;
    if (s < 1 || s > 23040) return 1'b0;
    j  = (s - 1) / 15;
    c  = (s - 1) % 15;
    w  = model_word(j / 24);
    bv = w[23 - (j % 24)];
    return (c < (bv ? 8 : 4)) ? 1'b1 : 1'b0;
  endfunction

  task automatic run_frame(input int nsamp, input bit hold, input bit poke);
    m_r = red_board;
    m_g = green_board;
    m_b = blue_board;
    frame_valid = 1'b1;
    for (int s = 0; s < nsamp; s++) begin
      @(negedge clk);
      dq[s]  = data_out;
      dnq[s] = frame_done;
      rq[s]  = frame_ready;
      if (s == 0) frame_valid = 1'b0;
      if (poke && (s == 500 || s == 7000)) frame_valid = 1'b1;
      if (poke && (s == 501 || s == 7001)) frame_valid = 1'b0;
      if (poke && s == 1000) begin
        red_board   = 64'h0;
        green_board = 64'h5555_5555_5555_5555;
        blue_board  = 64'h0;
      end
      if (hold && s >= 20000) frame_valid = 1'b1;
      if (hold && s == 23500) begin
        red_board   = 64'h0000_0000_0000_0001;
        green_board = 64'h0000_0000_4000_0000;
        blue_board  = 64'h0;
      end
    end
  endtask

  task automatic analyze(input string tag, input int wave_last, input bit full);
    int bad = 0, first_bad = -1, dcnt = 0, dpos = -1, rbad = 0, rises = 0, sbad = 0, prev = -1;
    for (int s = 0; s <= wave_last; s++) begin
      if (dq[s] !== exp_dout(s)) begin
        bad++;
        if (first_bad < 0) first_bad = s;
      end
    end
    chk({tag, "_wave"}, bad, 0);
    if (bad != 0) $display("  %s first waveform difference at sample %0d", tag, first_bad);
    if (full) begin
      for (int s = 0; s <= 24041; s++) begin
        if (dnq[s] === 1'b1) begin
          dcnt++;
          dpos = s;
        end
        if (s <= 24040 && rq[s] !== 1'b0) rbad++;
        if (s >= 1 && s <= 23040 && dq[s] === 1'b1 && dq[s-1] !== 1'b1) begin
          rises++;
          if (prev >= 0 && (s - prev) != 15) sbad++;
          prev = s;
        end
      end
      chk({tag, "_bit_count"}, rises, 1536);
      chk({tag, "_bit_period"}, sbad, 0);
      chk({tag, "_done_pulses"}, dcnt, 1);
      chk({tag, "_done_latency"}, dpos, 24040);
      chk({tag, "_ready_busy"}, rbad, 0);
      chk({tag, "_ready_after"}, rq[24041], 1);
    end
  endtask

  function automatic int high_len(input int start);
    int n = 0;
    while (start + n < NS && dq[start + n] === 1'b1) n++;
    return n;
  endfunction

  initial begin
    int highs;
    int first_rise;

    // Reset behaviour
    repeat (3) @(negedge clk);
    chk("rst_dout", data_out, 0);
    chk("rst_done", frame_done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", frame_ready, 1);
    chk("rel_dout", data_out, 0);
    chk("rel_done", frame_done, 0);
    repeat (4) @(negedge clk);
    chk("idle_ready", frame_ready, 1);
    chk("idle_dout", data_out, 0);

    // Single red pixel 0: only R5 (sent bit 10) is a long pulse
    red_board = 64'h0000_0000_0000_0001;
    run_frame(24042, 1'b0, 1'b0);
    analyze("red1", 24041, 1'b1);
    chk("px0_b0_hi", high_len(1), 4);
    chk("px0_b8_hi", high_len(1 + 15 * 8), 4);
    chk("px0_b10_hi", high_len(1 + 15 * 10), 8);
    chk("px0_b15_hi", high_len(1 + 15 * 15), 4);

    // All cells lit, mid-frame valid pulses and board changes, valid held at the end
    red_board   = 64'hFFFF_FFFF_FFFF_FFFF;
    green_board = 64'hFFFF_FFFF_FFFF_FFFF;
    blue_board  = 64'hFFFF_FFFF_FFFF_FFFF;
    run_frame(24044, 1'b1, 1'b1);
    analyze("ones", 24042, 1'b1);
    first_rise = -1;
    for (int s = 23041; s < NS; s++) begin
      if (first_rise < 0 && dq[s] === 1'b1) first_rise = s;
    end
    chk("b2b_next_rise", first_rise, 24043);
    frame_valid = 1'b0;

    // Back-to-back frame started at sample 24042; abort it at pixel 30
    for (int k = 2; k <= 10801; k++) @(negedge clk);
    chk("p30_start_hi", data_out, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_dout", data_out, 0);
    highs = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (data_out !== 1'b0) highs++;
    end
    chk("abort_no_pulse", highs, 0);
    chk("abort_done", frame_done, 0);
    rst_n       = 1'b1;
    red_board   = 64'h0;
    green_board = 64'h0000_0000_4000_0000;
    blue_board  = 64'h0000_0000_0000_0001;
    @(negedge clk);
    chk("abort_rel_ready", frame_ready, 1);

    // Fresh frame must begin with pixel 0 (blue), not pixel 30 (green)
    run_frame(400, 1'b0, 1'b0);
    analyze("restart", 375, 1'b0);
    chk("restart_b18_hi", high_len(1 + 15 * 18), 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
